gmii_link_partner_tx: RTL and testbench



---
 rtl/gmii_link_partner_pkg.sv | 34 +++
 rtl/gmii_crc32_byte.sv | 25 ++
 rtl/gmii_link_partner_tx.sv | 255 +++++++++++++++++++++++++
 tb/tb_gmii_link_partner_tx.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_link_partner_pkg.sv
// Shared types and constants for the GMII link-partner frame source.
// Holds the FSM state enum, the GMII output symbol struct and the
// CRC-32 / preamble constants used by gmii_link_partner_tx and gmii_crc32_byte.
package gmii_link_partner_pkg;

    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned CRC_W        = 32;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned PRE_CNT_W    = 3;
    localparam int unsigned PREAMBLE_LEN = 7;

    localparam logic [CRC_W-1:0]  CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [CRC_W-1:0]  CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [BYTE_W-1:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [BYTE_W-1:0] SFD_BYTE      = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_DRAIN,
        ST_IFG
    } state_t;

    // One GMII receive-direction symbol as presented to the MAC.
    typedef struct packed {
        logic [BYTE_W-1:0] rxd;
        logic              dv;
        logic              er;
    } gmii_sym_t;

endpackage

// File: rtl/gmii_crc32_byte.sv
// Combinational IEEE 802.3 CRC-32 step (reflected, poly 0xEDB88320),
// folding one data byte LSB-first into the running CRC.
// Ports:
//   crc_in     - current CRC register value
//   data       - byte to fold in
//   crc_next_c - CRC after folding data
module gmii_crc32_byte
    import gmii_link_partner_pkg::*;
(
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [BYTE_W-1:0] data,
    output logic [CRC_W-1:0]  crc_next_c
);

    // Byte-wide XOR up front, then eight shift/reduce steps.
    always_comb begin
        logic [CRC_W-1:0] c;
        c = crc_in ^ CRC_W'(data);
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        crc_next_c = c;
    end

endmodule

// File: rtl/gmii_link_partner_tx.sv
// PHY-side GMII frame source: turns an 8-bit AXI-stream payload into a
// GMII receive-direction stream (preamble/SFD, payload, optional pad,
// optional FCS, inter-frame gap) for driving a MAC's GMII receive pins.
// Macro GMII_LINK_PARTNER_TX_FCS_EN: when defined, the CRC-32 FCS is generated
// and appended; when undefined, no CRC logic is built and payload (plus any
// pad) is emitted verbatim with error/frame_sent tied to the last byte.
// Ports:
//   clk, rst_n                 - GMII clock, async active-low reset
//   s_axis_tdata/tvalid/tready - payload stream; tlast ends frame,
//   s_axis_tlast/tuser           tuser on tlast beat corrupts the frame
//   gmii_rxd/rx_dv/rx_er       - GMII symbol stream toward the MAC
//   ifg_delay                  - requested gap, floored at MIN_IFG
//   frame_sent                 - pulse after the final byte of a frame
//   underflow                  - pulse when the source starves mid-frame
module gmii_link_partner_tx
    import gmii_link_partner_pkg::*;
#(
    parameter bit          ENABLE_PADDING   = 1'b1,
    parameter int unsigned MIN_FRAME_LENGTH = 64,
    parameter int unsigned MIN_IFG          = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic [BYTE_W-1:0] gmii_rxd,
    output logic              gmii_rx_dv,
    output logic              gmii_rx_er,
    input  logic [7:0]        ifg_delay,
    output logic              frame_sent,
    output logic              underflow
);

    localparam logic [CNT_W-1:0] PAD_TARGET = CNT_W'(MIN_FRAME_LENGTH - 4);
    localparam logic [7:0]       MIN_IFG_B  = 8'(MIN_IFG);

    state_t               state_q, state_n;
    gmii_sym_t            sym_q, sym_n;
    logic                 tready_q, tready_n;
    logic                 frame_sent_q, frame_sent_n;
    logic                 underflow_q, underflow_n;
    logic [PRE_CNT_W-1:0] pre_cnt_q, pre_cnt_n;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_n;
    logic [7:0]           ifg_cnt_q, ifg_cnt_n;
    logic                 tuser_q, tuser_n;
    logic                 sent_pend_q, sent_pend_n;

    logic [7:0]           ifg_eff_c;
    logic [CNT_W-1:0]     cnt_inc_c;

    assign ifg_eff_c = (ifg_delay > MIN_IFG_B) ? ifg_delay : MIN_IFG_B;
    assign cnt_inc_c = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);

`ifdef GMII_LINK_PARTNER_TX_FCS_EN
    logic [CRC_W-1:0]  crc_q, crc_n;
    logic [CRC_W-1:0]  crc_next_c;
    logic [CRC_W-1:0]  fcs_c;
    logic [BYTE_W-1:0] crc_din_c;
    logic [1:0]        fcs_idx_q, fcs_idx_n;

    // Pad bytes are zeros; everything else folds the incoming payload byte.
    assign crc_din_c = (state_q == ST_PAD) ? '0 : s_axis_tdata;
    assign fcs_c     = ~crc_q;

    gmii_crc32_byte u_crc (
        .crc_in     (crc_q),
        .data       (crc_din_c),
        .crc_next_c (crc_next_c)
    );
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sym_q        <= '0;
            tready_q     <= 1'b0;
            frame_sent_q <= 1'b0;
            underflow_q  <= 1'b0;
            pre_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            ifg_cnt_q    <= '0;
            tuser_q      <= 1'b0;
            sent_pend_q  <= 1'b0;
`ifdef GMII_LINK_PARTNER_TX_FCS_EN
            crc_q        <= CRC32_INIT;
            fcs_idx_q    <= '0;
`endif
        end else begin
            state_q      <= state_n;
            sym_q        <= sym_n;
            tready_q     <= tready_n;
            frame_sent_q <= frame_sent_n;
            underflow_q  <= underflow_n;
            pre_cnt_q    <= pre_cnt_n;
            byte_cnt_q   <= byte_cnt_n;
            ifg_cnt_q    <= ifg_cnt_n;
            tuser_q      <= tuser_n;
            sent_pend_q  <= sent_pend_n;
`ifdef GMII_LINK_PARTNER_TX_FCS_EN
            crc_q        <= crc_n;
            fcs_idx_q    <= fcs_idx_n;
`endif
        end
    end

    // Next state and next registered outputs. tready is computed one cycle
    // ahead so the registered value is high exactly in accepting cycles.
    always_comb begin
        state_n      = state_q;
        sym_n        = '0;
        tready_n     = 1'b0;
        frame_sent_n = 1'b0;
        underflow_n  = 1'b0;
        pre_cnt_n    = pre_cnt_q;
        byte_cnt_n   = byte_cnt_q;
        ifg_cnt_n    = ifg_cnt_q;
        tuser_n      = tuser_q;
        sent_pend_n  = sent_pend_q;
`ifdef GMII_LINK_PARTNER_TX_FCS_EN
        crc_n        = crc_q;
        fcs_idx_n    = fcs_idx_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    state_n    = ST_PREAMBLE;
                    sym_n      = '{rxd: PREAMBLE_BYTE, dv: 1'b1, er: 1'b0};
                    pre_cnt_n  = PRE_CNT_W'(1);
                    byte_cnt_n = '0;
                    tuser_n    = 1'b0;
`ifdef GMII_LINK_PARTNER_TX_FCS_EN
                    crc_n      = CRC32_INIT;
`endif
                end
            end

            // pre_cnt counts preamble bytes already on the wire.
            ST_PREAMBLE: begin
                if (pre_cnt_q == PRE_CNT_W'(PREAMBLE_LEN)) begin
                    sym_n    = '{rxd: SFD_BYTE, dv: 1'b1, er: 1'b0};
                    tready_n = 1'b1;
                    state_n  = ST_PAYLOAD;
                end else begin
                    sym_n     = '{rxd: PREAMBLE_BYTE, dv: 1'b1, er: 1'b0};
                    pre_cnt_n = pre_cnt_q + PRE_CNT_W'(1);
                end
            end

            ST_PAYLOAD: begin
                if (s_axis_tvalid) begin
                    sym_n      = '{rxd: s_axis_tdata, dv: 1'b1, er: 1'b0};
                    byte_cnt_n = cnt_inc_c;
`ifdef GMII_LINK_PARTNER_TX_FCS_EN
                    crc_n      = crc_next_c;
`endif
                    if (s_axis_tlast) begin
                        tuser_n = s_axis_tuser;
                        if (ENABLE_PADDING && (cnt_inc_c < PAD_TARGET)) begin
                            state_n = ST_PAD;
                        end else begin
`ifdef GMII_LINK_PARTNER_TX_FCS_EN
                            state_n   = ST_FCS;
                            fcs_idx_n = '0;
`else
                            sym_n.er    = s_axis_tuser;
                            state_n     = ST_IFG;
                            ifg_cnt_n   = ifg_eff_c;
                            sent_pend_n = 1'b1;
`endif
                        end
                    end else begin
                        tready_n = 1'b1;
                    end
                end else begin
                    // Source starved: flag one errored symbol, then discard the rest.
                    sym_n       = '{rxd: '0, dv: 1'b1, er: 1'b1};
                    underflow_n = 1'b1;
                    tready_n    = 1'b1;
                    state_n     = ST_DRAIN;
                end
            end

            ST_PAD: begin
                sym_n      = '{rxd: '0, dv: 1'b1, er: 1'b0};
                byte_cnt_n = cnt_inc_c;
`ifdef GMII_LINK_PARTNER_TX_FCS_EN
                crc_n      = crc_next_c;
                if (cnt_inc_c >= PAD_TARGET) begin
                    state_n   = ST_FCS;
                    fcs_idx_n = '0;
                end
`else
                if (cnt_inc_c >= PAD_TARGET) begin
                    sym_n.er    = tuser_q;
                    state_n     = ST_IFG;
                    ifg_cnt_n   = ifg_eff_c;
                    sent_pend_n = 1'b1;
                end
`endif
            end

`ifdef GMII_LINK_PARTNER_TX_FCS_EN
            // ~CRC, least significant byte first.
            ST_FCS: begin
                sym_n = '{rxd: fcs_c[{fcs_idx_q, 3'b000} +: BYTE_W], dv: 1'b1, er: 1'b0};
                if (fcs_idx_q == 2'd3) begin
                    sym_n.er    = tuser_q;
                    state_n     = ST_IFG;
                    ifg_cnt_n   = ifg_eff_c;
                    sent_pend_n = 1'b1;
                end else begin
                    fcs_idx_n = fcs_idx_q + 2'd1;
                end
            end
`endif

            ST_DRAIN: begin
                tready_n = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    tready_n  = 1'b0;
                    state_n   = ST_IFG;
                    ifg_cnt_n = ifg_eff_c;
                end
            end

            // frame_sent lands in the first idle cycle after a completed frame.
            ST_IFG: begin
                frame_sent_n = sent_pend_q;
                sent_pend_n  = 1'b0;
                if (ifg_cnt_q > 8'd1) begin
                    ifg_cnt_n = ifg_cnt_q - 8'd1;
                end else begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign gmii_rxd      = sym_q.rxd;
    assign gmii_rx_dv    = sym_q.dv;
    assign gmii_rx_er    = sym_q.er;
    assign s_axis_tready = tready_q;
    assign frame_sent    = frame_sent_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_gmii_link_partner_tx.sv
// Scoreboard bench for gmii_link_partner_tx. Two instances (padding off / on)
// share one stimulus bus; sel routes tvalid to one and its outputs to the monitor.
module tb_gmii_link_partner_tx;

`ifdef GMII_LINK_PARTNER_TX_FCS_EN
    localparam int FCS_LEN = 4;
`else
    localparam int FCS_LEN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tdata;
    logic       tvalid, tlast, tuser;
    logic [7:0] ifg_delay;
    int         sel;

    always #4 clk = ~clk;

    logic       tvalid_np, tvalid_p;
    logic       tready_np, tready_p, dv_np, dv_p, er_np, er_p, fs_np, fs_p, uf_np, uf_p;
    logic [7:0] rxd_np, rxd_p;

    assign tvalid_np = tvalid && (sel == 0);
    assign tvalid_p  = tvalid && (sel == 1);

    gmii_link_partner_tx #(.ENABLE_PADDING(1'b0), .MIN_FRAME_LENGTH(64), .MIN_IFG(12)) dut_np (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_np), .s_axis_tready(tready_np),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .gmii_rxd(rxd_np), .gmii_rx_dv(dv_np), .gmii_rx_er(er_np),
        .ifg_delay(ifg_delay), .frame_sent(fs_np), .underflow(uf_np)
    );

    gmii_link_partner_tx #(.ENABLE_PADDING(1'b1), .MIN_FRAME_LENGTH(64), .MIN_IFG(12)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_p), .s_axis_tready(tready_p),
        .s_axis_tlast(tlast), .s_axis_tuser(tuser),
        .gmii_rxd(rxd_p), .gmii_rx_dv(dv_p), .gmii_rx_er(er_p),
        .ifg_delay(ifg_delay), .frame_sent(fs_p), .underflow(uf_p)
    );

    logic       m_tready, m_dv, m_er, m_fs, m_uf;
    logic [7:0] m_rxd;
    assign m_tready = (sel == 0) ? tready_np : tready_p;
    assign m_dv     = (sel == 0) ? dv_np     : dv_p;
    assign m_er     = (sel == 0) ? er_np     : er_p;
    assign m_fs     = (sel == 0) ? fs_np     : fs_p;
    assign m_uf     = (sel == 0) ? uf_np     : uf_p;
    assign m_rxd    = (sel == 0) ? rxd_np    : rxd_p;

    typedef struct packed {
        logic [7:0] d;
        logic       er;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] pay[$];
    logic [7:0] exp_bytes[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int run_len = 0, last_len = 0, gap_len = 0, last_gap = 0, fs_cnt = 0, uf_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected symbol per dv cycle and tracks run/gap lengths.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (m_fs) fs_cnt++;
            if (m_uf) uf_cnt++;
            if (m_dv) begin
                if (run_len == 0) last_gap = gap_len;
                run_len++;
                gap_len = 0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_symbol actual rxd=%02h er=%0b required none", m_rxd, m_er);
                end else begin
                    e = sb.pop_front();
                    if (m_rxd !== e.d || m_er !== e.er) begin
                        errors++;
                        $display("FAIL symbol actual rxd=%02h er=%0b required rxd=%02h er=%0b",
                                 m_rxd, m_er, e.d, e.er);
                    end
                end
            end else begin
                if (run_len != 0) last_len = run_len;
                run_len = 0;
                gap_len++;
                if (m_er !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL er_outside_dv actual=%0b required=0", m_er);
                end
            end
        end else begin
            run_len = 0;
            gap_len = 0;
        end
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Push preamble/SFD then exp_bytes; er set on the last byte when tu=1.
    task automatic push_exp(input bit tu);
        for (int i = 0; i < 7; i++) sb.push_back('{d: 8'h55, er: 1'b0});
        sb.push_back('{d: 8'hD5, er: 1'b0});
        for (int i = 0; i < exp_bytes.size(); i++)
            sb.push_back('{d: exp_bytes[i], er: (tu && (i == exp_bytes.size() - 1))});
    endtask

    // Reference model of the emitted frame body from pay.
    task automatic build_model(input bit pad_en);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        exp_bytes.delete();
        for (int i = 0; i < pay.size(); i++) begin
            exp_bytes.push_back(pay[i]);
            c = crc_upd(c, pay[i]);
        end
        if (pad_en) begin
            while (exp_bytes.size() < 60) begin
                exp_bytes.push_back(8'h00);
                c = crc_upd(c, 8'h00);
            end
        end
`ifdef GMII_LINK_PARTNER_TX_FCS_EN
        c = ~c;
        for (int k = 0; k < 4; k++) exp_bytes.push_back(c[8*k +: 8]);
`endif
    endtask

    // Drives pay; if stall_at >= 0, drops tvalid for 2 cycles after that many accepts.
    task automatic drive(input bit tu, input int stall_at);
        int  idx = 0;
        int  budget = 0;
        bit  stalled = 1'b0;
        bit  acc;
        while (idx < pay.size()) begin
            if (idx == stall_at && !stalled) begin
                tvalid = 1'b0;
                tlast  = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                stalled = 1'b1;
            end
            tvalid = 1'b1;
            tdata  = pay[idx];
            tlast  = (idx == pay.size() - 1);
            tuser  = tlast ? tu : 1'b0;
            @(negedge clk);
            acc = m_tready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            budget++;
            if (budget > 3000) begin
                checks++;
                errors++;
                $display("FAIL drive_timeout actual accepted=%0d required=%0d", idx, pay.size());
                break;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    task automatic wait_done();
        int budget = 0;
        while (sb.size() != 0 && budget < 3000) begin
            @(posedge clk);
            budget++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL wait_timeout actual pending=%0d required=0", sb.size());
        end
        repeat (30) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs0, uf0;
        rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = '0;
        ifg_delay = 8'd0; sel = 0;
        #20;
        chk("rst_rxd_np", 32'(rxd_np), 32'h0);  chk("rst_dv_np", 32'(dv_np), 32'h0);
        chk("rst_er_np", 32'(er_np), 32'h0);    chk("rst_rdy_np", 32'(tready_np), 32'h0);
        chk("rst_fs_np", 32'(fs_np), 32'h0);    chk("rst_uf_np", 32'(uf_np), 32'h0);
        chk("rst_rxd_p", 32'(rxd_p), 32'h0);    chk("rst_dv_p", 32'(dv_p), 32'h0);
        chk("rst_rdy_p", 32'(tready_p), 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // CRC check value on the unpadded instance.
        for (int t = 0; t < 2; t++) begin
            sel = 0;
            pay.delete();
            for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
`ifndef GMII_LINK_PARTNER_TX_FCS_EN
            pay.push_back(8'h26); pay.push_back(8'h39); pay.push_back(8'hF4); pay.push_back(8'hCB);
`endif
            exp_bytes.delete();
            for (int i = 0; i < 9; i++) exp_bytes.push_back(8'h31 + 8'(i));
            exp_bytes.push_back(8'h26); exp_bytes.push_back(8'h39);
            exp_bytes.push_back(8'hF4); exp_bytes.push_back(8'hCB);
            fs0 = fs_cnt; uf0 = uf_cnt;
            push_exp(t == 1);
            drive(t == 1, -1);
            wait_done();
            chk(t == 0 ? "crc_dv_len" : "err_dv_len", 32'(last_len), 32'd21);
            chk(t == 0 ? "crc_frame_sent" : "err_frame_sent", 32'(fs_cnt - fs0), 32'd1);
            chk("crc_no_underflow", 32'(uf_cnt - uf0), 32'd0);
        end

        // Padding of a 10-byte frame.
        sel = 1;
        pay.delete();
        for (int i = 1; i <= 10; i++) pay.push_back(8'(i));
        build_model(1'b1);
        fs0 = fs_cnt;
        push_exp(1'b0);
        drive(1'b0, -1);
        wait_done();
        chk("pad_dv_len", 32'(last_len), 32'(8 + 60 + FCS_LEN));
        chk("pad_frame_sent", 32'(fs_cnt - fs0), 32'd1);

        // Underflow after 20 of 100 bytes.
        sel = 1;
        pay.delete();
        for (int i = 0; i < 100; i++) pay.push_back(8'(i + 100));
        exp_bytes.delete();
        for (int i = 0; i < 20; i++) exp_bytes.push_back(8'(i + 100));
        exp_bytes.push_back(8'h00);
        fs0 = fs_cnt; uf0 = uf_cnt;
        push_exp(1'b1);
        drive(1'b0, 20);
        wait_done();
        chk("uf_dv_len", 32'(last_len), 32'd29);
        chk("uf_pulse", 32'(uf_cnt - uf0), 32'd1);
        chk("uf_no_frame_sent", 32'(fs_cnt - fs0), 32'd0);

        // Back-to-back frames: gap floored at MIN_IFG, then honoured when larger.
        for (int t = 0; t < 2; t++) begin
            sel = 0;
            ifg_delay = (t == 0) ? 8'd5 : 8'd20;
            for (int f = 0; f < 2; f++) begin
                pay.delete();
                for (int i = 0; i < 5; i++) pay.push_back(8'(8'hA0 + 8'(16 * f) + 8'(i)));
                build_model(1'b0);
                push_exp(1'b0);
                drive(1'b0, -1);
            end
            wait_done();
            chk(t == 0 ? "ifg_min" : "ifg_req", 32'(last_gap), (t == 0) ? 32'd12 : 32'd20);
        end
        ifg_delay = 8'd0;

        // Asynchronous reset in the middle of a payload.
        sel = 0;
        mon_en = 1'b0;
        tvalid = 1'b1; tdata = 8'h3C; tlast = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("mid_dv_before_rst", 32'(m_dv), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dv", 32'(m_dv), 32'h0);
        chk("mid_rst_rxd", 32'(m_rxd), 32'h0);
        chk("mid_rst_er", 32'(m_er), 32'h0);
        chk("mid_rst_rdy", 32'(m_tready), 32'h0);
        tvalid = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pay.delete();
        for (int i = 0; i < 5; i++) pay.push_back(8'(8'h10 + 8'(i)));
        build_model(1'b0);
        fs0 = fs_cnt;
        push_exp(1'b0);
        drive(1'b0, -1);
        wait_done();
        chk("post_rst_dv_len", 32'(last_len), 32'(8 + 5 + FCS_LEN));
        chk("post_rst_frame_sent", 32'(fs_cnt - fs0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
